// File: rtl/nl_distort_2sec_5th_1ch.sv
// Forward ADC non-linearity emulator: two-section 5th-order polynomial,
// evaluated by Horner's method at one multiply-add step per clock.
module nl_distort_2sec_5th_1ch (
    input  logic        clk,
    input  logic        reset,
    input  logic        srdyi,
    input  logic [20:0] x_lin,
    output logic        srdyo,
    output logic [20:0] x_adc,
    output logic        busy,
    output logic        drop,
    input  logic [31:0] coeff_2_5,
    input  logic [31:0] coeff_2_4,
    input  logic [31:0] coeff_2_3,
    input  logic [31:0] coeff_2_2,
    input  logic [31:0] coeff_2_1,
    input  logic [31:0] coeff_2_0,
    input  logic [31:0] coeff_1_5,
    input  logic [31:0] coeff_1_4,
    input  logic [31:0] coeff_1_3,
    input  logic [31:0] coeff_1_2,
    input  logic [31:0] coeff_1_1,
    input  logic [31:0] coeff_1_0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2:0]         k;
    logic               sect;      // 1: section 2 (x_lin > 0)
    logic               sect_new;
    logic signed [20:0] u;
    logic signed [31:0] acc;
    logic signed [31:0] coef;
    logic signed [31:0] c5_new;
    logic signed [52:0] prod;
    logic signed [52:0] prod_rnd;
    logic signed [32:0] q;
    logic signed [31:0] q_sat;
    logic signed [32:0] sum;
    logic signed [31:0] step;
    logic signed [32:0] r_full;
    logic signed [22:0] r;
    logic [20:0]        r_sat;

    assign busy     = (state != IDLE);
    assign sect_new = ~x_lin[20] & (|x_lin);
    assign c5_new   = sect_new ? signed'(coeff_2_5) : signed'(coeff_1_5);

    always_comb begin
        coef = '0;
        if (sect) begin
            case (k)
                3'd4:    coef = signed'(coeff_2_4);
                3'd3:    coef = signed'(coeff_2_3);
                3'd2:    coef = signed'(coeff_2_2);
                3'd1:    coef = signed'(coeff_2_1);
                default: coef = signed'(coeff_2_0);
            endcase
        end else begin
            case (k)
                3'd4:    coef = signed'(coeff_1_4);
                3'd3:    coef = signed'(coeff_1_3);
                3'd2:    coef = signed'(coeff_1_2);
                3'd1:    coef = signed'(coeff_1_1);
                default: coef = signed'(coeff_1_0);
            endcase
        end
    end

    // |acc*u| <= 2^51, so the rounding add cannot overflow 53 bits.
    always_comb begin
        prod     = 53'(acc) * 53'(u);
        prod_rnd = prod + 53'sd524288;
        q        = 33'(prod_rnd >>> 20);
        if (q[32] != q[31])
            q_sat = q[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            q_sat = q[31:0];
        sum = 33'(q_sat) + 33'(coef);
        if (sum[32] != sum[31])
            step = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            step = sum[31:0];
    end

    always_comb begin
        r_full = 33'(acc) + 33'sd512;
        r      = 23'(r_full >>> 10);
        if ((r[22:20] != 3'b000) && (r[22:20] != 3'b111))
            r_sat = r[22] ? 21'h10_0000 : 21'h0F_FFFF;
        else
            r_sat = r[20:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (srdyi) state_nx = ITER;
            ITER:    if (k == 3'd0) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            k     <= '0;
            u     <= '0;
            sect  <= 1'b0;
            x_adc <= '0;
            srdyo <= 1'b0;
            drop  <= 1'b0;
        end else begin
            srdyo <= 1'b0;
            drop  <= srdyi && (state != IDLE);
            case (state)
                IDLE: begin
                    if (srdyi) begin
                        u    <= x_lin;
                        sect <= sect_new;
                        acc  <= c5_new;
                        k    <= 3'd4;
                    end
                end
                ITER: begin
                    acc <= step;
                    if (k != 3'd0) k <= k - 3'd1;
                end
                OUT: begin
                    x_adc <= r_sat;
                    srdyo <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
